// File: rtl/ysyx_24110006_lsu.sv
// ysyx_24110006_lsu: load/store unit issuing one bus transaction per memory instruction.
module ysyx_24110006_lsu #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              i_clock,
  input  logic              i_reset,
  input  logic              i_valid,
  output logic              o_ready,
  input  logic              i_mem_ren,
  input  logic              i_mem_wen,
  input  logic [3:0]        i_mem_wmask,
  input  logic [2:0]        i_mem_read_t,
  input  logic [ADDR_W-1:0] i_mem_addr,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic [DATA_W-1:0] i_result,
  output logic              o_req_valid,
  input  logic              i_req_ready,
  output logic              o_req_wen,
  output logic [ADDR_W-1:0] o_req_addr,
  output logic [DATA_W-1:0] o_req_wdata,
  output logic [3:0]        o_req_wstrb,
  input  logic              i_rsp_valid,
  output logic              o_rsp_ready,
  input  logic [DATA_W-1:0] i_rsp_data,
  input  logic              i_rsp_err,
  output logic              o_valid,
  output logic [DATA_W-1:0] o_wb_data,
  output logic              o_err
);
  typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;
  state_t state, state_n;
  logic [1:0] sh, off;
  logic [2:0] read_t;
  logic is_word, is_half, bad_t, misal, mem, fault, accept, done_rsp;
  logic [DATA_W-1:0] r, ld;
  assign sh = i_mem_addr[1:0];
  // Access size comes from funct3 for loads and from the byte mask for stores.
  assign is_word = i_mem_ren ? i_mem_read_t[1:0] == 2'b10 : i_mem_wmask[3];
  assign is_half = i_mem_ren ? i_mem_read_t[1:0] == 2'b01 : i_mem_wmask[1] & ~i_mem_wmask[3];
  assign bad_t = i_mem_ren & (i_mem_read_t == 3'b011 | i_mem_read_t[2:1] == 2'b11);
  assign misal = (is_half & sh[0]) | (is_word & |sh);
  assign mem = i_mem_ren | i_mem_wen;
  assign fault = (i_mem_ren & i_mem_wen) | bad_t | misal;
  assign accept = i_valid & (state == IDLE);
  assign done_rsp = (state == WAIT) & i_rsp_valid;
  assign o_ready = state == IDLE;
  assign o_req_valid = state == REQ;
  assign o_rsp_ready = state == WAIT;
  assign o_valid = state == DONE;
  assign r = i_rsp_data >> {off, 3'b000};
  assign ld = read_t[1:0] == 2'b00 ? {{(DATA_W-8){~read_t[2] & r[7]}}, r[7:0]} :
              read_t[1:0] == 2'b01 ? {{(DATA_W-16){~read_t[2] & r[15]}}, r[15:0]} : r;
  always_comb begin
    state_n = state;
    case (state)
      IDLE: state_n = accept ? ((mem & ~fault) ? REQ : DONE) : IDLE;
      REQ:  state_n = i_req_ready ? WAIT : REQ;
      WAIT: state_n = i_rsp_valid ? DONE : WAIT;
      DONE: state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge i_clock)
    state <= i_reset ? IDLE : state_n;
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      o_wb_data <= '0;
      o_err <= 1'b0;
    end else if (accept) begin
      o_req_wen <= i_mem_wen;
      o_req_addr <= {i_mem_addr[ADDR_W-1:2], 2'b00};
      o_req_wstrb <= i_mem_wen ? i_mem_wmask << sh : 4'b0000;
      o_req_wdata <= i_wdata << {sh, 3'b000};
      off <= sh;
      read_t <= i_mem_read_t;
      o_wb_data <= mem ? '0 : i_result;
      o_err <= mem & fault;
    end else if (done_rsp) begin
      o_err <= i_rsp_err;
      o_wb_data <= (i_rsp_err | o_req_wen) ? '0 : ld;
    end
  end
endmodule
